// File: rtl/health_manager.sv
// Round-level health bookkeeping for both fighters: applies hit damage with
// per-player invulnerability windows and sequences IDLE -> FIGHT -> DRAIN -> KO_HOLD.
module health_manager #(
  parameter logic [8:0]  MAX_HEALTH     = 9'd300,
  parameter logic [31:0] INVULN_CYCLES  = 32'd5_000_000,
  parameter logic [31:0] KO_HOLD_CYCLES = 32'd200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       round_start,
  input  logic       hit_l,
  input  logic [7:0] dmg_l,
  input  logic       hit_r,
  input  logic [7:0] dmg_r,
  input  logic [8:0] final_health_l,
  input  logic [8:0] final_health_r,
  output logic [8:0] curr_health_l,
  output logic [8:0] curr_health_r,
  output logic       invuln_l,
  output logic       invuln_r,
  output logic       fight_active,
  output logic       ko,
  output logic [1:0] winner,
  output logic       round_over
);

  typedef enum logic [1:0] {
    IDLE,
    FIGHT,
    DRAIN,
    KO_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  health_l_q, health_l_d;
  logic [8:0]  health_r_q, health_r_d;
  logic [31:0] inv_cnt_l_q, inv_cnt_l_d;
  logic [31:0] inv_cnt_r_q, inv_cnt_r_d;
  logic [31:0] hold_q, hold_d;
  logic        invuln_l_q, invuln_l_d;
  logic        invuln_r_q, invuln_r_d;
  logic        fight_active_q, fight_active_d;
  logic        ko_q, ko_d;
  logic [1:0]  winner_q, winner_d;
  logic        round_over_q, round_over_d;

  logic        accept_l, accept_r;
  logic        drained_l, drained_r;

  function automatic logic [8:0] applyDamage(input logic [8:0] health, input logic [7:0] dmg);
    logic [8:0] dmg_ext;
    dmg_ext = {1'b0, dmg};
    return (health > dmg_ext) ? (health - dmg_ext) : 9'd0;
  endfunction

  // A player is "drained" once the bar has visibly caught up with a zero target.
  assign accept_l  = hit_l && (inv_cnt_l_q == 32'd0);
  assign accept_r  = hit_r && (inv_cnt_r_q == 32'd0);
  assign drained_l = (health_l_q != 9'd0) || (final_health_l == 9'd0);
  assign drained_r = (health_r_q != 9'd0) || (final_health_r == 9'd0);

  always_comb begin
    state_d      = state_q;
    health_l_d   = health_l_q;
    health_r_d   = health_r_q;
    inv_cnt_l_d  = (inv_cnt_l_q != 32'd0) ? (inv_cnt_l_q - 32'd1) : 32'd0;
    inv_cnt_r_d  = (inv_cnt_r_q != 32'd0) ? (inv_cnt_r_q - 32'd1) : 32'd0;
    hold_d       = hold_q;
    winner_d     = winner_q;
    round_over_d = 1'b0;

    case (state_q)
      IDLE: begin
        health_l_d = MAX_HEALTH;
        health_r_d = MAX_HEALTH;
        if (round_start) begin
          state_d  = FIGHT;
          winner_d = 2'b00;
        end
      end
      FIGHT: begin
        if (accept_l) begin
          health_l_d  = applyDamage(health_l_q, dmg_l);
          inv_cnt_l_d = INVULN_CYCLES - 32'd1;
        end
        if (accept_r) begin
          health_r_d  = applyDamage(health_r_q, dmg_r);
          inv_cnt_r_d = INVULN_CYCLES - 32'd1;
        end
        if ((health_l_q == 9'd0) || (health_r_q == 9'd0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained_l && drained_r) begin
          state_d  = KO_HOLD;
          winner_d = {health_l_q == 9'd0, health_r_q == 9'd0};
          hold_d   = KO_HOLD_CYCLES - 32'd1;
        end
      end
      KO_HOLD: begin
        if (hold_q == 32'd0) begin
          state_d      = IDLE;
          round_over_d = 1'b1;
          health_l_d   = MAX_HEALTH;
          health_r_d   = MAX_HEALTH;
          inv_cnt_l_d  = 32'd0;
          inv_cnt_r_d  = 32'd0;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    invuln_l_d     = (inv_cnt_l_d != 32'd0);
    invuln_r_d     = (inv_cnt_r_d != 32'd0);
    fight_active_d = (state_d == FIGHT);
    ko_d           = (state_d == KO_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      health_l_q     <= MAX_HEALTH;
      health_r_q     <= MAX_HEALTH;
      inv_cnt_l_q    <= 32'd0;
      inv_cnt_r_q    <= 32'd0;
      hold_q         <= 32'd0;
      invuln_l_q     <= 1'b0;
      invuln_r_q     <= 1'b0;
      fight_active_q <= 1'b0;
      ko_q           <= 1'b0;
      winner_q       <= 2'b00;
      round_over_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      health_l_q     <= health_l_d;
      health_r_q     <= health_r_d;
      inv_cnt_l_q    <= inv_cnt_l_d;
      inv_cnt_r_q    <= inv_cnt_r_d;
      hold_q         <= hold_d;
      invuln_l_q     <= invuln_l_d;
      invuln_r_q     <= invuln_r_d;
      fight_active_q <= fight_active_d;
      ko_q           <= ko_d;
      winner_q       <= winner_d;
      round_over_q   <= round_over_d;
    end
  end

  assign curr_health_l = health_l_q;
  assign curr_health_r = health_r_q;
  assign invuln_l      = invuln_l_q;
  assign invuln_r      = invuln_r_q;
  assign fight_active  = fight_active_q;
  assign ko            = ko_q;
  assign winner        = winner_q;
  assign round_over    = round_over_q;

endmodule
